// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register and its slots.
// No logic of its own.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage link carrying a control payload and a data payload.
// The master drives valid/ctrl/data; the slave drives ready.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_slot.sv
// One held entry (valid + ctrl + data); clear beats load, and clear leaves data untouched.
// Latency 1 cycle from load/clear to output; no flow control of its own.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else if (clear_i) begin
      // Bubble insertion: kill valid and control, keep the data bits as they were.
      vld_q  <= 1'b0;
      ctrl_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: SKID=1 is a 2-entry skid buffer with registered in_ready, SKID=0 a single
// slot with combinational ready; 1-cycle latency, FIFO order, flush squashes every held entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter bit SKID   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pipe_stage_reg_if.slave        in_if,
  pipe_stage_reg_if.master       out_if,
  output logic [1:0]             occupancy
);

  logic              in_xfer;
  logic              out_xfer;
  logic              head_load;
  logic              head_clr;
  logic [CTRL_W-1:0] head_ctrl_d;
  logic [DATA_W-1:0] head_data_d;
  logic              head_vld;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;

  assign in_xfer  = in_if.valid & in_if.ready;
  assign out_xfer = out_if.valid & out_if.ready;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk     (clk),
    .reset   (reset),
    .load_i  (head_load),
    .clear_i (head_clr),
    .ctrl_i  (head_ctrl_d),
    .data_i  (head_data_d),
    .vld_o   (head_vld),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data)
  );

  assign out_if.valid = head_vld;
  assign out_if.ctrl  = head_ctrl;
  assign out_if.data  = head_data;

  if (SKID) begin : g_skid
    state_t            state_q;
    state_t            state_d;
    logic              rdy_q;
    logic              head_sel_skid;
    logic              skid_load;
    logic              skid_clr;
    logic              skid_vld;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .ctrl_i  (in_if.ctrl),
      .data_i  (in_if.data),
      .vld_o   (skid_vld),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );

    always_comb begin
      state_d       = state_q;
      head_load     = 1'b0;
      head_clr      = 1'b0;
      head_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      if (flush) begin
        state_d  = EMPTY;
        head_clr = 1'b1;
        skid_clr = 1'b1;
      end else begin
        case (state_q)
          EMPTY: if (in_xfer) begin
            state_d   = ONE;
            head_load = 1'b1;
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              head_load = 1'b1;
            end else if (in_xfer) begin
              state_d   = TWO;
              skid_load = 1'b1;
            end else if (out_xfer) begin
              state_d  = EMPTY;
              head_clr = 1'b1;
            end
          end
          TWO: if (out_xfer) begin
            state_d       = ONE;
            head_load     = 1'b1;
            head_sel_skid = 1'b1;
            skid_clr      = 1'b1;
          end
          default: begin
            state_d  = EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
          end
        endcase
      end
      head_ctrl_d = head_sel_skid ? skid_ctrl : in_if.ctrl;
      head_data_d = head_sel_skid ? skid_data : in_if.data;
    end

    // Ready comes straight from a flop so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= EMPTY;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        rdy_q   <= (state_d != TWO);
      end
    end

    assign in_if.ready = rdy_q;
    assign occupancy   = state_q;
  end else begin : g_single
    always_comb begin
      head_load   = in_xfer & ~flush;
      head_clr    = flush | (out_xfer & ~in_xfer);
      head_ctrl_d = in_if.ctrl;
      head_data_d = in_if.data;
    end

    assign in_if.ready = ~head_vld | out_if.ready;
    assign occupancy   = {1'b0, head_vld};
  end

endmodule
